// File: rtl/usb_tx_serializer.sv
// USB full-speed TX line stage: byte serialiser with bit stuffing, NRZI
// encoding and SE0/SE0/J end-of-packet generation. All line activity is
// paced by the one-cycle bit-period strobe from the bit-timing counter.
module usb_tx_serializer #(
    parameter int DATA_W    = 8,
    parameter int STUFF_RUN = 6
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              shift_strobe,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_last,
    output logic              tx_ready,
    output logic              dplus_out,
    output logic              dminus_out,
    output logic              tx_busy,
    output logic              tx_error
);

    localparam int CNT_W = $clog2(STUFF_RUN + 1);
    localparam int IDX_W = $clog2(DATA_W + 1);

    // DATA/STUFF name the action taken on the next strobe; EOP1/EOP2/EOPJ
    // name the symbol currently on the line.
    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_STUFF,
        S_EOP1,
        S_EOP2,
        S_EOPJ
    } state_t;

    state_t             state, state_n;

    // Holding register (one byte of look-ahead)
    logic [DATA_W-1:0]  hold_data;
    logic               hold_last;
    logic               hold_full;
    logic               hold_acc;

    // Shifter: sh_data is pre-shifted so bit 0 is always the next bit out
    logic [DATA_W-1:0]  sh_data, sh_data_n;
    logic               sh_last, sh_last_n;
    logic [IDX_W-1:0]   sh_cnt, sh_cnt_n;
    logic               xfer;

    // Encoder state: line_k=1 means the NRZI level is currently K
    logic [CNT_W-1:0]   ones_cnt, ones_n;
    logic               line_k, line_k_n;
    logic               dp_n, dm_n;
    logic               busy_n;
    logic               err_n;

    // Data bit to push through the stuff/NRZI encoder this strobe
    logic               bit_en;
    logic               bit_val;

    // Consecutive-ones counter saturates at the stuff threshold
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (c == CNT_W'(STUFF_RUN))
            return c;
        else
            return c + CNT_W'(1);
    endfunction

    assign hold_acc = tx_valid && !hold_full;
    assign tx_ready = ~hold_full;

    // Next-state, shifter and line-level logic; only strobes advance anything
    always_comb begin
        state_n   = state;
        sh_data_n = sh_data;
        sh_last_n = sh_last;
        sh_cnt_n  = sh_cnt;
        ones_n    = ones_cnt;
        line_k_n  = line_k;
        dp_n      = dplus_out;
        dm_n      = dminus_out;
        busy_n    = tx_busy;
        err_n     = 1'b0;
        xfer      = 1'b0;
        bit_en    = 1'b0;
        bit_val   = 1'b0;

        if (shift_strobe) begin
            case (state)
                S_IDLE: begin
                    if (hold_full) begin
                        xfer      = 1'b1;
                        sh_data_n = hold_data >> 1;
                        sh_last_n = hold_last;
                        sh_cnt_n  = IDX_W'(1);
                        bit_en    = 1'b1;
                        bit_val   = hold_data[0];
                        busy_n    = 1'b1;
                    end
                end

                S_DATA: begin
                    if (sh_cnt == IDX_W'(DATA_W)) begin
                        // Current byte fully sent: end packet, chain next byte, or underrun
                        if (sh_last) begin
                            dp_n    = 1'b0;
                            dm_n    = 1'b0;
                            state_n = S_EOP1;
                        end else if (hold_full) begin
                            xfer      = 1'b1;
                            sh_data_n = hold_data >> 1;
                            sh_last_n = hold_last;
                            sh_cnt_n  = IDX_W'(1);
                            bit_en    = 1'b1;
                            bit_val   = hold_data[0];
                        end else begin
                            err_n   = 1'b1;
                            dp_n    = 1'b0;
                            dm_n    = 1'b0;
                            state_n = S_EOP1;
                        end
                    end else begin
                        sh_data_n = sh_data >> 1;
                        sh_cnt_n  = sh_cnt + IDX_W'(1);
                        bit_en    = 1'b1;
                        bit_val   = sh_data[0];
                    end
                end

                S_STUFF: begin
                    // Inserted zero: toggle the line, shifter position untouched
                    line_k_n = ~line_k;
                    ones_n   = '0;
                    dp_n     = ~line_k_n;
                    dm_n     = line_k_n;
                    state_n  = S_DATA;
                end

                S_EOP1: begin
                    state_n = S_EOP2;
                end

                S_EOP2: begin
                    dp_n    = 1'b1;
                    dm_n    = 1'b0;
                    state_n = S_EOPJ;
                end

                S_EOPJ: begin
                    busy_n   = 1'b0;
                    ones_n   = '0;
                    line_k_n = 1'b0;
                    state_n  = S_IDLE;
                end

                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end

        // NRZI encode a data bit: 0 toggles, 1 holds and counts toward a stuff
        if (bit_en) begin
            if (bit_val) begin
                ones_n   = sat_inc(ones_cnt);
                line_k_n = line_k;
            end else begin
                ones_n   = '0;
                line_k_n = ~line_k;
            end
            dp_n    = ~line_k_n;
            dm_n    = line_k_n;
            state_n = (bit_val && (ones_n == CNT_W'(STUFF_RUN))) ? S_STUFF : S_DATA;
        end
    end

    // Control state and line outputs
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= S_IDLE;
            hold_full  <= 1'b0;
            sh_cnt     <= '0;
            sh_last    <= 1'b0;
            ones_cnt   <= '0;
            line_k     <= 1'b0;
            dplus_out  <= 1'b1;
            dminus_out <= 1'b0;
            tx_busy    <= 1'b0;
            tx_error   <= 1'b0;
        end else begin
            state      <= state_n;
            hold_full  <= (hold_full && !xfer) || hold_acc;
            sh_cnt     <= sh_cnt_n;
            sh_last    <= sh_last_n;
            ones_cnt   <= ones_n;
            line_k     <= line_k_n;
            dplus_out  <= dp_n;
            dminus_out <= dm_n;
            tx_busy    <= busy_n;
            tx_error   <= err_n;
        end
    end

    // Byte storage; contents are qualified by hold_full / sh_cnt
    always_ff @(posedge clk) begin
        if (hold_acc) begin
            hold_data <= tx_data;
            hold_last <= tx_last;
        end
        sh_data <= sh_data_n;
    end

endmodule

// File: tb/tb_usb_tx_serializer.sv
// Scoreboard bench for usb_tx_serializer: stimulus pushes hand-computed
// line symbols, a monitor pops and compares them on every strobe.
module tb_usb_tx_serializer;

    localparam logic [1:0] LJ  = 2'b10;
    localparam logic [1:0] LK  = 2'b01;
    localparam logic [1:0] SE0 = 2'b00;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       shift_strobe = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_last = 1'b0;
    logic       tx_ready, dplus_out, dminus_out, tx_busy, tx_error;

    typedef struct packed {
        logic [1:0] line;
        logic       busy;
        logic       err;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   err_pulses = 0;
    int   strobe_div = 0;
    logic prev_busy = 1'b0;

    usb_tx_serializer #(.DATA_W(8), .STUFF_RUN(6)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .shift_strobe (shift_strobe),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_last      (tx_last),
        .tx_ready     (tx_ready),
        .dplus_out    (dplus_out),
        .dminus_out   (dminus_out),
        .tx_busy      (tx_busy),
        .tx_error     (tx_error)
    );

    always #5 clk = ~clk;

    // One-cycle strobe every 4 clocks
    initial begin
        forever begin
            @(negedge clk);
            strobe_div++;
            shift_strobe = (strobe_div % 4 == 0);
        end
    end

    // Count clocks on which tx_error is high
    always @(negedge clk) begin
        if (tx_error) err_pulses++;
    end

    // Monitor: compare line after every strobe edge
    always @(posedge clk) begin
        if (!n_rst) begin
            prev_busy = 1'b0;
        end else if (shift_strobe) begin
            #1;
            if (n_rst) begin
                if (tx_busy || prev_busy) begin
                    checks++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_symbol: line=%b busy=%b err=%b, no symbol expected",
                                 {dplus_out, dminus_out}, tx_busy, tx_error);
                    end else begin
                        mon_e = q.pop_front();
                        if ({dplus_out, dminus_out} !== mon_e.line || tx_busy !== mon_e.busy ||
                            tx_error !== mon_e.err) begin
                            errors++;
                            $display("FAIL line_symbol @%0t: got line=%b busy=%b err=%b, required line=%b busy=%b err=%b",
                                     $time, {dplus_out, dminus_out}, tx_busy, tx_error,
                                     mon_e.line, mon_e.busy, mon_e.err);
                        end
                    end
                end else begin
                    checks++;
                    if ({dplus_out, dminus_out} !== LJ || tx_error !== 1'b0) begin
                        errors++;
                        $display("FAIL idle_line @%0t: got line=%b err=%b, required line=10 err=0",
                                 $time, {dplus_out, dminus_out}, tx_error);
                    end
                end
                prev_busy = tx_busy;
            end
        end
    end

    task automatic push(input logic [1:0] l, input logic b, input logic e);
        exp_t x;
        x.line = l;
        x.busy = b;
        x.err  = e;
        q.push_back(x);
    endtask

    // 'J', 'K', '0' (SE0), all with busy=1
    task automatic push_seq(input string s);
        for (int i = 0; i < s.len(); i++) begin
            case (s[i])
                "J":     push(LJ, 1'b1, 1'b0);
                "K":     push(LK, 1'b1, 1'b0);
                default: push(SE0, 1'b1, 1'b0);
            endcase
        end
    endtask

    task automatic push_eop();
        push_seq("00J");
        push(LJ, 1'b0, 1'b0);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        int t;
        t = 0;
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = d;
        tx_last  = l;
        while (!tx_ready && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (!tx_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: byte %h not taken, tx_ready=%b required 1", d, tx_ready);
        end else begin
            @(posedge clk);
        end
        #1;
        tx_valid = 1'b0;
        tx_last  = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while (q.size() != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d symbols pending, required 0", name, q.size());
            q.delete();
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (dplus_out !== 1'b1 || dminus_out !== 1'b0 || tx_ready !== 1'b1 ||
            tx_busy !== 1'b0 || tx_error !== 1'b0) begin
            errors++;
            $display("FAIL %s: got dp=%b dm=%b ready=%b busy=%b err=%b, required dp=1 dm=0 ready=1 busy=0 err=0",
                     name, dplus_out, dminus_out, tx_ready, tx_busy, tx_error);
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_state");
        n_rst = 1'b1;

        // Idle: 20 strobes of J
        repeat (80) @(negedge clk);
        check_reset_outputs("idle_after_20_strobes");

        // SYNC + 0xA5
        push_seq("KJKJKJKK");
        push_seq("KJJKJJKK");
        push_eop();
        send_byte(8'h80, 1'b0);
        send_byte(8'hA5, 1'b1);
        wait_drain("sync_a5");

        // 0xFF: SYNC's trailing 1 plus five 1s triggers the stuff, then three 1s
        push_seq("KJKJKJKK");
        push_seq("KKKKKJJJJ");
        push_eop();
        send_byte(8'h80, 1'b0);
        send_byte(8'hFF, 1'b1);
        wait_drain("stuff_ff");

        // 0xFC: six 1s end the byte, stuff bit precedes EOP
        push_seq("KJKJKJKK");
        push_seq("JKKKKKKKJ");
        push_eop();
        send_byte(8'h80, 1'b0);
        send_byte(8'hFC, 1'b1);
        wait_drain("stuff_at_end");

        // Underrun: no last byte
        push_seq("KJKJKJKK");
        push(SE0, 1'b1, 1'b1);
        push_seq("0J");
        push(LJ, 1'b0, 1'b0);
        send_byte(8'h80, 1'b0);
        wait_drain("underrun");
        checks++;
        if (err_pulses != 1) begin
            errors++;
            $display("FAIL underrun_pulse: tx_error high for %0d clocks, required 1", err_pulses);
        end

        // Next packet after underrun
        push_seq("KJKJKJKK");
        push_eop();
        send_byte(8'h80, 1'b1);
        wait_drain("after_underrun");

        // Reset mid-byte
        push_seq("KJKJKJKK");
        push_seq("KJJKJJKK");
        push_eop();
        send_byte(8'h80, 1'b0);
        send_byte(8'hA5, 1'b1);
        repeat (10) @(negedge clk);
        #2;
        n_rst = 1'b0;
        #1;
        check_reset_outputs("async_mid_reset");
        q.delete();
        repeat (3) @(negedge clk);
        n_rst = 1'b1;

        push_seq("KJKJKJKK");
        push_eop();
        send_byte(8'h80, 1'b1);
        wait_drain("after_reset");

        repeat (20) @(negedge clk);
        checks++;
        if (err_pulses != 1) begin
            errors++;
            $display("FAIL total_error_pulses: got %0d, required 1", err_pulses);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
